// File: rtl/aes_128_dec_iter.sv
// Iterative AES-128 inverse cipher: one round per clock, round keys rolled backwards from k10.
// Optional macro AES_DEC_LASTKEY_LOAD_EN adds key_is_last to load the round-10 key directly.
module aes_128_dec_iter (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key,
    input  logic         key_load,
`ifdef AES_DEC_LASTKEY_LOAD_EN
    input  logic         key_is_last,
`endif
    output logic         key_ready,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);
    localparam logic [2:0] S_NOKEY  = 3'd0;
    localparam logic [2:0] S_KEYEXP = 3'd1;
    localparam logic [2:0] S_READY  = 3'd2;
    localparam logic [2:0] S_ROUND  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]   state_r;
    logic [127:0] k10_r, kr_r, s_r, out_data_r;
    logic [3:0]   rnd_r;
    logic [31:0]  sb_in_s, temp_s;
    logic [127:0] fwd_key_s, prev_key_s, isb_s, ark_s, round_s;
    logic         key_acc_s, last_s, accept_s;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8) and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p, r;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] b;
        b = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(b);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    // byte i sits at row i%4, column i/4; row r is rotated right by r columns
    function automatic logic [127:0] inv_shift_sub(input logic [127:0] s);
        logic [127:0] o;
        int           src;
        o = 128'h0;
        for (int i = 0; i < 16; i++) begin
            src = 4 * (((i / 4) - (i % 4) + 4) % 4) + (i % 4);
            o[127 - 8 * i -: 8] = inv_sbox(s[127 - 8 * src -: 8]);
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = 128'h0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32 * c -: 8];
            a1 = s[119 - 32 * c -: 8];
            a2 = s[111 - 32 * c -: 8];
            a3 = s[103 - 32 * c -: 8];
            o[127 - 32 * c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119 - 32 * c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111 - 32 * c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103 - 32 * c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

`ifdef AES_DEC_LASTKEY_LOAD_EN
    assign last_s = key_is_last;
`else
    assign last_s = 1'b0;
`endif

    assign key_ready = (state_r == S_NOKEY) || (state_r == S_READY);
    assign out_valid = (state_r == S_DONE);
    assign in_ready  = ((state_r == S_READY) && !key_load) || ((state_r == S_DONE) && out_ready);
    assign accept_s  = in_valid && in_ready;
    assign key_acc_s = key_ready && key_load;
    assign out_data  = out_data_r;

    // Shared key-schedule S-boxes, forward/inverse key step and one inverse round
    always_comb begin
        if (state_r == S_KEYEXP) begin
            sb_in_s = k10_r[31:0];
        end else begin
            sb_in_s = kr_r[31:0] ^ kr_r[63:32];
        end
        temp_s = sub_word({sb_in_s[23:0], sb_in_s[31:24]}) ^ {rcon(rnd_r), 24'h000000};
        fwd_key_s[127:96] = k10_r[127:96] ^ temp_s;
        fwd_key_s[95:64]  = k10_r[95:64] ^ k10_r[127:96] ^ temp_s;
        fwd_key_s[63:32]  = k10_r[63:32] ^ k10_r[95:64] ^ k10_r[127:96] ^ temp_s;
        fwd_key_s[31:0]   = k10_r[31:0] ^ k10_r[63:32] ^ k10_r[95:64] ^ k10_r[127:96] ^ temp_s;
        prev_key_s = {kr_r[127:96] ^ temp_s, kr_r[127:96] ^ kr_r[95:64],
                      kr_r[95:64] ^ kr_r[63:32], kr_r[63:32] ^ kr_r[31:0]};
        isb_s = inv_shift_sub(s_r);
        ark_s = isb_s ^ prev_key_s;
        if (rnd_r == 4'd1) begin
            round_s = ark_s;
        end else begin
            round_s = inv_mix(ark_s);
        end
    end

    // Control FSM with key expansion, round datapath and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= S_NOKEY;
            k10_r      <= 128'h0;
            kr_r       <= 128'h0;
            s_r        <= 128'h0;
            out_data_r <= 128'h0;
            rnd_r      <= 4'd0;
        end else begin
            case (state_r)
                S_NOKEY, S_READY: begin
                    if (key_acc_s && last_s) begin
                        k10_r   <= key;
                        state_r <= S_READY;
                    end else if (key_acc_s) begin
                        k10_r   <= key;
                        rnd_r   <= 4'd1;
                        state_r <= S_KEYEXP;
                    end else if (accept_s) begin
                        s_r     <= in_data ^ k10_r;
                        kr_r    <= k10_r;
                        rnd_r   <= 4'd10;
                        state_r <= S_ROUND;
                    end else begin
                        state_r <= state_r;
                    end
                end
                S_KEYEXP: begin
                    k10_r <= fwd_key_s;
                    rnd_r <= rnd_r + 4'd1;
                    if (rnd_r == 4'd10) begin
                        state_r <= S_READY;
                    end else begin
                        state_r <= S_KEYEXP;
                    end
                end
                S_ROUND: begin
                    s_r   <= round_s;
                    kr_r  <= prev_key_s;
                    rnd_r <= rnd_r - 4'd1;
                    if (rnd_r == 4'd1) begin
                        out_data_r <= round_s;
                        state_r    <= S_DONE;
                    end else begin
                        state_r <= S_ROUND;
                    end
                end
                S_DONE: begin
                    if (accept_s) begin
                        s_r     <= in_data ^ k10_r;
                        kr_r    <= k10_r;
                        rnd_r   <= 4'd10;
                        state_r <= S_ROUND;
                    end else if (out_ready) begin
                        state_r <= S_READY;
                    end else begin
                        state_r <= S_DONE;
                    end
                end
                default: state_r <= S_NOKEY;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_128_dec_iter.sv
// Self-checking bench for aes_128_dec_iter: FIPS vectors plus random blocks against a table-driven model.
module tb_aes_128_dec_iter;
    logic         clk, rst_n, key_load, key_ready, in_valid, in_ready, out_valid, out_ready;
    logic [127:0] key, in_data, out_data;
`ifdef AES_DEC_LASTKEY_LOAD_EN
    logic         key_is_last;
`endif

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] K10_C1 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;

    int total, bad;
    logic [7:0] sbox_t [256];
    logic [7:0] isbox_t [256];

    aes_128_dec_iter dut (
        .clk(clk), .rst_n(rst_n), .key(key), .key_load(key_load),
`ifdef AES_DEC_LASTKEY_LOAD_EN
        .key_is_last(key_is_last),
`endif
        .key_ready(key_ready), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        int r, x, y;
        r = 0; x = {24'h0, a}; y = {24'h0, b};
        while (y != 0) begin
            if ((y & 1) != 0) r = r ^ x;
            x = x << 1;
            if ((x & 'h100) != 0) x = x ^ 'h11b;
            y = y >> 1;
        end
        return r[7:0];
    endfunction

    // S-box from its definition: brute-force field inverse, then the affine map
    task automatic build_tables();
        logic [7:0] inv, v, c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            for (int i = 0; i < 8; i++)
                v[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
            sbox_t[a]  = v;
            isbox_t[v] = 8'(a);
        end
    endtask

    function automatic logic [127:0] ref_decrypt(input logic [127:0] k, input logic [127:0] ct);
        logic [31:0]  w [44];
        logic [31:0]  t;
        logic [7:0]   rc, a0, a1, a2, a3;
        logic [7:0]   st [16];
        logic [7:0]   tmp [16];
        logic [127:0] pt;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]], sbox_t[t[31:24]]} ^ {rc, 24'h000000};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 16; i++) st[i] = ct[127-8*i -: 8] ^ w[40 + i/4][31-8*(i%4) -: 8];
        for (int r = 9; r >= 0; r--) begin
            for (int i = 0; i < 16; i++) tmp[i] = isbox_t[st[(i%4) + 4*(((i/4) - (i%4) + 4) % 4)]];
            for (int i = 0; i < 16; i++) st[i] = tmp[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
            if (r > 0) begin
                for (int c = 0; c < 4; c++) begin
                    a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
                    st[4*c]   = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
                    st[4*c+1] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
                    st[4*c+2] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
                    st[4*c+3] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
                end
            end
        end
        for (int i = 0; i < 16; i++) pt[127-8*i -: 8] = st[i];
        return pt;
    endfunction

    // Stimulus only: pulse key_load, optionally pulse again kl_at cycles into expansion
    task automatic do_load(input logic [127:0] k, input int kl_at, input logic [127:0] kl_key, output int cyc);
        int n;
        n = 0;
        while (!key_ready && n < 50) begin @(posedge clk); #1; n++; end
        key = k; key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0;
        cyc = 0;
        while (!key_ready && cyc < 50) begin
            key_load = (cyc == kl_at);
            if (cyc == kl_at) key = kl_key;
            @(posedge clk); #1; cyc++;
        end
        key_load = 1'b0;
    endtask

    // Stimulus only: send one block with out_ready high, return plaintext and accept-to-valid latency
    task automatic do_block(input logic [127:0] ct, input int kl_at, input logic [127:0] kl_key,
                            output logic [127:0] pt, output int lat);
        int n;
        in_valid = 1'b1; in_data = ct; #1;
        n = 0;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin in_valid = 1'b0; lat = -1; pt = 128'h0; return; end
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!out_valid && lat < 50) begin
            key_load = (lat == kl_at);
            if (lat == kl_at) key = kl_key;
            @(posedge clk); #1; lat++;
        end
        key_load = 1'b0;
        pt = out_data;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (key_ready !== 1'b1) begin bad++; $display("FAIL reset_key_ready got=%b want=1", key_ready); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (out_data !== 128'h0) begin bad++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL nokey_in_ready got=%b want=0", in_ready); end
    endtask

    task automatic test_fips_c1();
        int cyc, lat;
        logic [127:0] pt;
        do_load(KEY_C1, -1, 128'h0, cyc);
        total++; if (cyc !== 10) begin bad++; $display("FAIL c1_keyexp_cycles got=%0d want=10", cyc); end
        do_block(CT_C1, -1, 128'h0, pt, lat);
        total++; if (lat !== 10) begin bad++; $display("FAIL c1_latency got=%0d want=10", lat); end
        total++; if (pt !== PT_C1) begin bad++; $display("FAIL c1_plaintext got=%h want=%h", pt, PT_C1); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL c1_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_fips_b_stall();
        int cyc, lat;
        do_load(KEY_B, -1, 128'h0, cyc);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = CT_B; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b_ready got=%b want=1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        total++; if (lat !== 10) begin bad++; $display("FAIL b_latency got=%0d want=10", lat); end
        total++; if (out_data !== PT_B) begin bad++; $display("FAIL b_plaintext got=%h want=%h", out_data, PT_B); end
        in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            total++;
            if (out_valid !== 1'b1 || out_data !== PT_B || in_ready !== 1'b0) begin
                bad++; $display("FAIL b_stall cyc=%0d got v=%b r=%b d=%h want v=1 r=0 d=%h", i, out_valid, in_ready, out_data, PT_B);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b_drop got=%b want=0", out_valid); end
        total++; if (out_data !== PT_B) begin bad++; $display("FAIL b_hold got=%h want=%h", out_data, PT_B); end
    endtask

    task automatic test_alternate();
        int cyc, lat;
        logic [127:0] pt;
        for (int i = 0; i < 8; i++) begin
            do_load((i % 2 == 0) ? KEY_C1 : KEY_B, -1, 128'h0, cyc);
            total++; if (cyc !== 10) begin bad++; $display("FAIL alt_keyexp i=%0d got=%0d want=10", i, cyc); end
            do_block((i % 2 == 0) ? CT_C1 : CT_B, -1, 128'h0, pt, lat);
            total++;
            if (pt !== ((i % 2 == 0) ? PT_C1 : PT_B) || lat !== 10) begin
                bad++; $display("FAIL alt_block i=%0d got=%h lat=%0d want=%h lat=10", i, pt, lat, (i % 2 == 0) ? PT_C1 : PT_B);
            end
        end
    endtask

    task automatic test_key_load_ignored();
        int cyc, lat;
        logic [127:0] pt;
        do_load(KEY_C1, 4, KEY_B, cyc);
        total++; if (cyc !== 10) begin bad++; $display("FAIL ign_keyexp_cycles got=%0d want=10", cyc); end
        do_block(CT_C1, 3, KEY_B, pt, lat);
        total++; if (pt !== PT_C1) begin bad++; $display("FAIL ign_plaintext got=%h want=%h", pt, PT_C1); end
        key = KEY_B; key_load = 1'b1; in_valid = 1'b1; in_data = CT_C1; #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL collide_in_ready got=%b want=0", in_ready); end
        @(posedge clk); #1;
        key_load = 1'b0; in_valid = 1'b0;
        total++; if (key_ready !== 1'b0) begin bad++; $display("FAIL collide_keyexp got=%b want=0", key_ready); end
        cyc = 0;
        while (!key_ready && cyc < 50) begin @(posedge clk); #1; cyc++; end
        total++; if (cyc !== 10) begin bad++; $display("FAIL collide_keyexp_cycles got=%0d want=10", cyc); end
        do_block(CT_B, -1, 128'h0, pt, lat);
        total++; if (pt !== PT_B) begin bad++; $display("FAIL collide_newkey got=%h want=%h", pt, PT_B); end
    endtask

    // Random blocks under one random key; scoreboard ordered by acceptance
    task automatic test_back_to_back(input bit stall);
        logic [127:0] k, e;
        logic [127:0] cts [6];
        logic [127:0] exp_q [$];
        int acc [$];
        int cyc, sent, got, cycle;
        k = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 6; i++) cts[i] = {$urandom, $urandom, $urandom, $urandom};
        do_load(k, -1, 128'h0, cyc);
        sent = 0; got = 0; cycle = 0;
        while (got < 6 && cycle < 2000) begin
            in_valid = (sent < 6);
            in_data = (sent < 6) ? cts[sent] : 128'h0;
            out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
            #1;
            if (out_valid && out_ready) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++; $display("FAIL b2b_unexpected got=%h want=none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin bad++; $display("FAIL b2b_data n=%0d got=%h want=%h", got, out_data, e); end
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_decrypt(k, in_data));
                acc.push_back(cycle);
                sent++;
            end
            @(posedge clk); #1; cycle++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        total++; if (got !== 6) begin bad++; $display("FAIL b2b_count got=%0d want=6", got); end
        if (!stall) begin
            for (int i = 1; i < acc.size(); i++) begin
                total++;
                if (acc[i] - acc[i-1] !== 11) begin bad++; $display("FAIL b2b_gap i=%0d got=%0d want=11", i, acc[i] - acc[i-1]); end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midround();
        int cyc, lat;
        logic [127:0] pt;
        do_load(KEY_B, -1, 128'h0, cyc);
        in_valid = 1'b1; in_data = CT_B; #1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0; #1;
        total++;
        if (out_valid !== 1'b0 || key_ready !== 1'b1 || in_ready !== 1'b0 || out_data !== 128'h0) begin
            bad++; $display("FAIL midreset got v=%b kr=%b ir=%b d=%h want 0 1 0 0", out_valid, key_ready, in_ready, out_data);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b1; in_data = CT_B; #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midreset_keylost got=%b want=0", in_ready); end
        in_valid = 1'b0;
        do_load(KEY_B, -1, 128'h0, cyc);
        do_block(CT_B, -1, 128'h0, pt, lat);
        total++; if (pt !== PT_B) begin bad++; $display("FAIL midreset_resend got=%h want=%h", pt, PT_B); end
    endtask

`ifdef AES_DEC_LASTKEY_LOAD_EN
    task automatic test_lastkey();
        int lat;
        logic [127:0] pt;
        key = K10_C1; key_is_last = 1'b1; key_load = 1'b1;
        @(posedge clk); #1;
        key_load = 1'b0; key_is_last = 1'b0;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL lastkey_ready got=%b want=1", in_ready); end
        do_block(CT_C1, -1, 128'h0, pt, lat);
        total++; if (pt !== PT_C1) begin bad++; $display("FAIL lastkey_plaintext got=%h want=%h", pt, PT_C1); end
    endtask
`endif

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        rst_n = 1'b0; key = 128'h0; key_load = 1'b0;
        in_valid = 1'b0; in_data = 128'h0; out_ready = 1'b1;
`ifdef AES_DEC_LASTKEY_LOAD_EN
        key_is_last = 1'b0;
`endif
        build_tables();
        total++;
        if (ref_decrypt(KEY_C1, CT_C1) !== PT_C1) begin bad++; $display("FAIL model_c1 got=%h want=%h", ref_decrypt(KEY_C1, CT_C1), PT_C1); end
        test_reset();
        test_fips_c1();
        test_fips_b_stall();
        test_alternate();
        test_key_load_ignored();
        test_back_to_back(1'b0);
        test_back_to_back(1'b1);
        test_reset_midround();
`ifdef AES_DEC_LASTKEY_LOAD_EN
        test_lastkey();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
